// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing recovery: rebuilds pixel coordinates and lock status from h_sync/v_sync edges.
// Optional saturating fault counter on err_count is built when VGA_RX_ERR_CNT_EN is defined.
module vga_sync_receiver #(
    parameter int H_VISIBLE    = 640,
    parameter int H_BACK_PORCH = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_BACK_PORCH = 33,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       display_enable,
    output logic       locked,
    output logic [9:0] h_last,
    output logic [9:0] v_total,
    output logic       sync_error,
    output logic [7:0] err_count
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] VERIFY  = 2'd2;
    localparam logic [1:0] LOCKED  = 2'd3;

    localparam logic [9:0] POS_MAX = 10'd1023;
    localparam logic [9:0] H_START = 10'(H_BACK_PORCH);
    localparam logic [9:0] H_END   = 10'(H_BACK_PORCH + H_VISIBLE);
    localparam logic [9:0] V_START = 10'(V_BACK_PORCH);
    localparam logic [9:0] V_END   = 10'(V_BACK_PORCH + V_VISIBLE);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    logic       hq_q, hqq_q, vq_q, vqq_q;
    logic [9:0] h_pos_q, h_pos_d;
    logic [9:0] v_pos_q, v_pos_d;
    logic       v_arm_q, v_arm_d;
    logic [9:0] h_last_q, h_last_d;
    logic [9:0] v_total_q, v_total_d;
    logic [1:0] state_q, state_d;
    logic [9:0] ref_h_q, ref_h_d;
    logic [9:0] ref_v_q, ref_v_d;
    logic [3:0] match_q, match_d;
    logic       frame_bad_q, frame_bad_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       de_q, de_d;
    logic       err_q, err_d;

    logic h_rise, v_rise, h_sat, h_bad, v_bad, active, frame_ok;

    assign h_rise = hq_q & ~hqq_q;
    assign v_rise = vq_q & ~vqq_q;
    assign h_sat  = (h_pos_q == POS_MAX);
    assign h_bad  = h_rise && (h_pos_q != ref_h_q);
    assign v_bad  = (v_pos_q != ref_v_q);
    assign active = (h_pos_q >= H_START) && (h_pos_q < H_END) &&
                    (v_pos_q >= V_START) && (v_pos_q < V_END);
    // A frame whose line counter ran into saturation never counts as consistent.
    assign frame_ok = !frame_bad_q && !h_sat && !v_bad;

    always_comb begin
        // NOTE: every _d is given a default first, so no branch can leave it unassigned and infer a latch.
        h_pos_d     = h_rise ? 10'd0 : (h_sat ? h_pos_q : h_pos_q + 10'd1);
        h_last_d    = h_rise ? h_pos_q : h_last_q;
        v_total_d   = v_rise ? v_pos_q : v_total_q;
        v_pos_d     = v_pos_q;
        v_arm_d     = v_arm_q | v_rise;
        frame_bad_d = v_rise ? 1'b0 : (frame_bad_q | h_bad | h_sat);
        state_d     = state_q;
        ref_h_d     = ref_h_q;
        ref_v_d     = ref_v_q;
        match_d     = match_q;
        err_d       = 1'b0;

        if (h_rise) begin
            if (v_arm_q || v_rise) begin
                v_pos_d = 10'd1;
                v_arm_d = 1'b0;
            end else if (v_pos_q != POS_MAX) begin
                v_pos_d = v_pos_q + 10'd1;
            end
        end

        case (state_q)
            SEARCH: begin
                if (v_rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (v_rise) begin
                    ref_h_d = h_last_q;
                    ref_v_d = v_pos_q;
                    match_d = 4'd0;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (v_rise) begin
                    if (frame_ok) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 >= LOCK_N) state_d = LOCKED;
                    end else begin
                        ref_h_d = h_last_q;
                        ref_v_d = v_pos_q;
                        match_d = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (h_bad || (v_rise && v_bad) || h_sat) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase

        x_d  = active ? h_pos_q - H_START : 10'd0;
        y_d  = active ? v_pos_q - V_START : 10'd0;
        de_d = active && (state_q == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hq_q        <= 1'b1;
            hqq_q       <= 1'b1;
            vq_q        <= 1'b1;
            vqq_q       <= 1'b1;
            h_pos_q     <= '0;
            v_pos_q     <= '0;
            v_arm_q     <= 1'b0;
            h_last_q    <= '0;
            v_total_q   <= '0;
            state_q     <= SEARCH;
            ref_h_q     <= '0;
            ref_v_q     <= '0;
            match_q     <= '0;
            frame_bad_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            de_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            hq_q        <= h_sync;
            hqq_q       <= hq_q;
            vq_q        <= v_sync;
            vqq_q       <= vq_q;
            h_pos_q     <= h_pos_d;
            v_pos_q     <= v_pos_d;
            v_arm_q     <= v_arm_d;
            h_last_q    <= h_last_d;
            v_total_q   <= v_total_d;
            state_q     <= state_d;
            ref_h_q     <= ref_h_d;
            ref_v_q     <= ref_v_d;
            match_q     <= match_d;
            frame_bad_q <= frame_bad_d;
            x_q         <= x_d;
            y_q         <= y_d;
            de_q        <= de_d;
            err_q       <= err_d;
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

    assign x_pixel        = x_q;
    assign y_pixel        = y_q;
    assign display_enable = de_q;
    assign locked         = (state_q == LOCKED);
    assign h_last         = h_last_q;
    assign v_total        = v_total_q;
    assign sync_error     = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a scaled 100x20 timing (64x12 visible) to keep runs short.
// Generator counter p advances once per clock; sync outputs are registered, so they reflect p-1.
module tb_vga_sync_receiver;

    localparam int HT = 100;
    localparam int VT = 20;
    localparam int FRAME = HT * VT;
`ifdef VGA_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       h_sync;
    logic       v_sync;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       display_enable;
    logic       locked;
    logic [9:0] h_last;
    logic [9:0] v_total;
    logic       sync_error;
    logic [7:0] err_count;

    int  vectors    = 0;
    int  miscompares = 0;
    int  p          = 0;
    int  err_seen   = 0;
    bit  h_force    = 1'b0;

    vga_sync_receiver #(
        .H_VISIBLE   (64),
        .H_BACK_PORCH(16),
        .V_VISIBLE   (12),
        .V_BACK_PORCH(4),
        .LOCK_FRAMES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .h_sync        (h_sync),
        .v_sync        (v_sync),
        .x_pixel       (x_pixel),
        .y_pixel       (y_pixel),
        .display_enable(display_enable),
        .locked        (locked),
        .h_last        (h_last),
        .v_total       (v_total),
        .sync_error    (sync_error),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line: 64 visible, 8 front porch, 12 sync (72..83), 16 back porch.
    function automatic logic hs_of(input int q);
        int hc;
        hc = q % HT;
        return !(hc >= 72 && hc < 84);
    endfunction

    // Frame: 12 visible, 2 front porch, 2 sync (14..15), 4 back porch.
    function automatic logic vs_of(input int q);
        int vc;
        vc = (q % FRAME) / HT;
        return !(vc == 14 || vc == 15);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d (p=%0d)", tag, obs, exp, p);
        end
    endtask

    task automatic tick();
        h_sync = h_force ? 1'b1 : hs_of(p);
        v_sync = vs_of(p);
        p = p + 1;
        @(posedge clk);
        #1;
        if (sync_error) err_seen++;
    endtask

    task automatic run_to(input int target);
        while (p < target) tick();
    endtask

    task automatic check_pixels();
        int q, hc, vc;
        bit act;
        q   = (p - 3) % FRAME;
        hc  = q % HT;
        vc  = q / HT;
        act = (hc < 64) && (vc < 12);
        check("x_pixel", 32'(x_pixel), act ? hc : 0);
        check("y_pixel", 32'(y_pixel), act ? vc : 0);
        check("display_enable", 32'(display_enable), 32'(act));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".x_pixel"}, 32'(x_pixel), 0);
        check({tag, ".y_pixel"}, 32'(y_pixel), 0);
        check({tag, ".display_enable"}, 32'(display_enable), 0);
        check({tag, ".locked"}, 32'(locked), 0);
        check({tag, ".h_last"}, 32'(h_last), 0);
        check({tag, ".v_total"}, 32'(v_total), 0);
        check({tag, ".sync_error"}, 32'(sync_error), 0);
        check({tag, ".err_count"}, 32'(err_count), 0);
    endtask

    initial begin
        int err_base;
        int locked_seen;

        reset  = 1'b0;
        h_sync = 1'b1;
        v_sync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Clean timing: lock one cycle after the 4th detected v rise (p=7601).
        run_to(3 * FRAME + 1601);
        check("lock.before", 32'(locked), 0);
        tick();
        check("lock.after", 32'(locked), 1);
        check("lock.h_last", 32'(h_last), 99);
        check("lock.v_total", 32'(v_total), 20);
        check("lock.err_count", 32'(err_count), 0);
        check("lock.no_error", 32'(err_seen), 0);

        // Full-frame sweep while locked.
        run_to(4 * FRAME);
        while (p < 5 * FRAME) begin
            tick();
            check_pixels();
        end
        check("sweep.locked", 32'(locked), 1);
        check("sweep.no_error", 32'(err_seen), 0);

        // Drop the h_sync pulse of line 5: next h rise sees h_pos=199.
        run_to(5 * FRAME + 572);
        h_force = 1'b1;
        run_to(5 * FRAME + 584);
        h_force = 1'b0;
        run_to(5 * FRAME + 685);
        check("drop.pre_err", 32'(sync_error), 0);
        check("drop.pre_locked", 32'(locked), 1);
        tick();
        check("drop.sync_error", 32'(sync_error), 1);
        check("drop.locked", 32'(locked), 0);
        check("drop.err_count", 32'(err_count), CNT_EN ? 1 : 0);
        tick();
        check("drop.pulse_end", 32'(sync_error), 0);
        check("drop.pulses", 32'(err_seen), 1);

        // Relock: v rises at 11601, 13601, 15601, 17601.
        run_to(8 * FRAME + 1601);
        check("relock1.before", 32'(locked), 0);
        tick();
        check("relock1.after", 32'(locked), 1);

        // Hold h_sync high from line 1: h_pos hits 1023 at p=19109, fault at 19110.
        run_to(9 * FRAME + 100);
        h_force = 1'b1;
        run_to(9 * FRAME + 1109);
        check("sat.pre_err", 32'(sync_error), 0);
        check("sat.pre_locked", 32'(locked), 1);
        tick();
        check("sat.sync_error", 32'(sync_error), 1);
        check("sat.locked", 32'(locked), 0);
        check("sat.err_count", 32'(err_count), CNT_EN ? 2 : 0);
        run_to(9 * FRAME + 1500);
        h_force = 1'b0;
        check("sat.pulses", 32'(err_seen), 2);

        run_to(12 * FRAME + 1601);
        check("relock2.before", 32'(locked), 0);
        tick();
        check("relock2.after", 32'(locked), 1);
        check("relock2.h_last", 32'(h_last), 99);
        check("relock2.v_total", 32'(v_total), 20);

        // One-cycle reset mid-frame, then a full relock sequence.
        run_to(13 * FRAME + 500);
        reset = 1'b0;
        tick();
        check_all_zero("midreset");
        reset = 1'b1;
        run_to(16 * FRAME + 1601);
        check("relock3.before", 32'(locked), 0);
        tick();
        check("relock3.after", 32'(locked), 1);
        check("relock3.err_count", 32'(err_count), 0);
        run_to(17 * FRAME);
        repeat (200) begin
            tick();
            check_pixels();
        end

        // h_sync stuck high from reset: never locks, never faults.
        h_force = 1'b1;
        reset   = 1'b0;
        tick();
        reset   = 1'b1;
        err_base    = err_seen;
        locked_seen = 0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            tick();
            if (locked) locked_seen++;
        end
        check("stuck.locked_cycles", 32'(locked_seen), 0);
        check("stuck.sync_errors", 32'(err_seen - err_base), 0);
        check("stuck.h_last", 32'(h_last), 0);
        check("stuck.v_total", 32'(v_total), 0);
        check("stuck.x_pixel", 32'(x_pixel), 0);
        check("stuck.err_count", 32'(err_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
